// File: rtl/port_egress.sv
// Egress drain stage for one switch port: reads the packet FIFO one word at a
// time and re-frames the stream into sop/eop-marked packets on valid/ready.
//
// state | meaning
// IDLE  | between packets, waiting for the FIFO to go non-empty
// FETCH | issue one FIFO read; waits here indefinitely on a mid-packet underrun
// LOAD  | read data returns; register word, sop/eop flags, capture LEN
// SEND  | present word downstream until accepted
module port_egress #(
    parameter int W_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [W_WIDTH-1:0]   fifo_data,
    output logic                 fifo_rd,
    output logic [W_WIDTH-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [W_WIDTH:0] IDX_LEN = (W_WIDTH + 1)'(2);
    localparam logic [W_WIDTH:0] IDX_ONE = (W_WIDTH + 1)'(1);

    state_t               state;
    logic [W_WIDTH:0]     idx;
    logic [W_WIDTH-1:0]   len;
    logic [W_WIDTH:0]     last_idx;
    logic                 eop_next;

    // idx is one bit wider than LEN so the last index LEN+2 never wraps
    assign last_idx = {1'b0, len} + IDX_LEN;

    always_comb begin
        eop_next = 1'b0;
        if (idx == IDX_LEN)
            eop_next = (fifo_data == '0);
        else if (idx > IDX_LEN)
            eop_next = (idx == last_idx);
    end

    assign fifo_rd = (state == FETCH) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            busy      <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (!fifo_empty) begin
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!fifo_empty)
                        state <= LOAD;
                end
                LOAD: begin
                    out_data  <= fifo_data;
                    out_sop   <= (idx == '0);
                    out_eop   <= eop_next;
                    out_valid <= 1'b1;
                    if (idx == IDX_LEN)
                        len <= fifo_data;
                    state <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_eop) begin
                            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                            idx     <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_egress.sv
// Randomized and directed bench for port_egress against a packet-level model:
// expected words, sop/eop and packet count are derived from DA/SA/LEN framing.
module tb_port_egress;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_rd;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sop;
    logic          out_eop;
    logic          busy;
    logic [CW-1:0] pkt_cnt;

    port_egress #(.W_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sop;
        logic         eop;
    } exp_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W-1:0]  fq[$];
    exp_t          eq[$];
    bit            stall = 0;
    bit            rd_seen = 0;
    bit            rdy_rand = 0;
    bit            chk_gap = 0;
    bit            pkt_open = 0;
    bit            prev_v = 0;
    bit            prev_r = 0;
    logic [W-1:0]  prev_d = '0;
    logic [CW-1:0] exp_cnt = '0;
    int            n_rd = 0;
    int            n_acc = 0;
    int            cyc = 0;
    int            last_acc = 0;
    int            wrap_seq[5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d, input bit s, input bit e);
        exp_t x;
        x.d = d;
        x.sop = s;
        x.eop = e;
        fq.push_back(d);
        eq.push_back(x);
    endtask

    // Packet is DA, SA, LEN, then LEN payload words; eop on its last word
    task automatic push_pkt(input logic [W-1:0] da, input logic [W-1:0] sa,
                            input logic [W-1:0] len, input logic [W-1:0] p0,
                            input logic [W-1:0] p1);
        logic [W-1:0] p;
        push_word(da, 1'b1, 1'b0);
        push_word(sa, 1'b0, 1'b0);
        push_word(len, 1'b0, len == '0);
        for (int k = 0; k < int'(len); k++) begin
            p = (k == 0) ? p0 : (k == 1) ? p1 : W'($urandom);
            push_word(p, 1'b0, k == int'(len) - 1);
        end
    endtask

    task automatic flush_model();
        fq.delete();
        eq.delete();
        stall = 0;
        pkt_open = 0;
        prev_v = 0;
        prev_r = 0;
        exp_cnt = '0;
        n_rd = 0;
        n_acc = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},    32'(fifo_rd),   32'(0));
        chk({tag, "_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_sop"},   32'(out_sop),   32'(0));
        chk({tag, "_eop"},   32'(out_eop),   32'(0));
        chk({tag, "_busy"},  32'(busy),      32'(0));
        chk({tag, "_data"},  32'(out_data),  32'(0));
        chk({tag, "_cnt"},   32'(pkt_cnt),   32'(0));
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (eq.size() == 0 && !busy)
                break;
        end
        if (i == max_cyc)
            chk("idle_timeout", 32'(eq.size()), 32'(0));
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (out_valid)
                break;
        end
        if (i == max_cyc)
            chk(tag, 32'(out_valid), 32'(1));
    endtask

    // FIFO model: read data and empty flag change just after the clock edge
    initial forever begin
        @(negedge clk);
        rd_seen = fifo_rd;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rd_seen && fq.size() > 0)
            fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0) || stall;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand)
            out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: every accepted word, counter, busy, hold rules, in-flight bound
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            exp_t e;
            cyc++;
            chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
            chk("busy", 32'(busy), 32'(pkt_open || fifo_rd));
            if (fifo_rd) begin
                n_rd++;
                pkt_open = 1;
            end
            chk("inflight", 32'((n_rd < n_acc) || (n_rd - n_acc > 1)), 32'(0));
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_data", 32'(out_data), 32'(prev_d));
            end
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    chk("extra_word", 32'(eq.size()), 32'(1));
                end else begin
                    e = eq.pop_front();
                    chk("data", 32'(out_data), 32'(e.d));
                    chk("sop", 32'(out_sop), 32'(e.sop));
                    chk("eop", 32'(out_eop), 32'(e.eop));
                    if (chk_gap && !e.sop)
                        chk("word_period", 32'(cyc - last_acc), 32'(3));
                    if (e.eop) begin
                        exp_cnt = exp_cnt + CW'(1);
                        pkt_open = 0;
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
        end
    end

    initial begin
        // Reset held with the FIFO non-empty, then the basic 5-word packet
        rst_n = 1'b0;
        flush_model();
        push_pkt(8'h01, 8'h22, 8'h02, 8'hAA, 8'hBB);
        #1;
        chk_reset_outputs("rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_rd", 32'(fifo_rd), 32'(0));
            chk("rst_hold_valid", 32'(out_valid), 32'(0));
            chk("rst_hold_busy", 32'(busy), 32'(0));
            chk("rst_hold_cnt", 32'(pkt_cnt), 32'(0));
        end
        chk_gap = 1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_rd", 32'(fifo_rd), 32'(1));
        @(negedge clk);
        chk("load_rd", 32'(fifo_rd), 32'(0));
        chk("load_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        chk("first_valid", 32'(out_valid), 32'(1));
        chk("first_sop", 32'(out_sop), 32'(1));
        wait_idle(100);
        chk_gap = 0;
        chk("single_cnt", 32'(pkt_cnt), 32'(1));
        chk("single_reads", 32'(n_rd), 32'(5));

        // LEN=0 packet immediately followed by another
        push_pkt(8'h03, 8'h04, 8'h00, 8'h00, 8'h00);
        push_pkt(8'h05, 8'h06, 8'h01, 8'h5A, 8'h00);
        wait_idle(100);
        chk("len0_cnt", 32'(pkt_cnt), 32'(3));

        // Backpressure on the SA word for 10 cycles
        out_ready = 1'b0;
        push_pkt(8'h10, 8'h20, 8'h01, 8'h30, 8'h00);
        wait_valid("bp_da_timeout", 50);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_valid("bp_sa_timeout", 50);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_data", 32'(out_data), 32'(8'h20));
            chk("bp_rd", 32'(fifo_rd), 32'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle(100);
        chk("bp_cnt", 32'(pkt_cnt), 32'(0));

        // Underrun after the LEN word of a 4-payload packet
        begin
            int base;
            int i;
            base = n_rd;
            push_pkt(8'h51, 8'h52, 8'h04, 8'h53, 8'h54);
            for (i = 0; i < 50; i++) begin
                @(negedge clk);
                if (n_rd - base >= 3)
                    break;
            end
            if (i == 50)
                chk("ur_timeout", 32'(n_rd - base), 32'(3));
            stall = 1;
            repeat (3) @(negedge clk);
            repeat (20) begin
                @(negedge clk);
                chk("ur_busy", 32'(busy), 32'(1));
                chk("ur_rd", 32'(fifo_rd), 32'(0));
                chk("ur_valid", 32'(out_valid), 32'(0));
            end
            stall = 0;
            wait_idle(100);
            chk("ur_cnt", 32'(pkt_cnt), 32'(1));
        end

        // Reset in the middle of the payload
        begin
            int i;
            push_pkt(8'h61, 8'h62, 8'h0A, 8'hC3, 8'h3C);
            for (i = 0; i < 200; i++) begin
                @(negedge clk);
                if (n_acc >= 5 && out_valid)
                    break;
            end
            if (i == 200)
                chk("mid_timeout", 32'(n_acc), 32'(5));
            @(posedge clk);
            #2 rst_n = 1'b0;
            flush_model();
            #1;
            chk_reset_outputs("mid_rst");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (5) begin
                @(negedge clk);
                chk("post_rst_busy", 32'(busy), 32'(0));
                chk("post_rst_rd", 32'(fifo_rd), 32'(0));
            end
        end

        // Counter wrap: 1, 2, 3, 0, 1
        for (int k = 0; k < 5; k++) begin
            push_pkt(8'(8'h70 + k), 8'h71, 8'(k), 8'h72, 8'h73);
            wait_idle(200);
            chk("wrap_cnt", 32'(pkt_cnt), 32'(wrap_seq[k]));
        end

        // Random packets with random backpressure
        rdy_rand = 1;
        for (int k = 0; k < 25; k++)
            push_pkt(W'($urandom), W'($urandom), W'($urandom_range(0, 6)),
                     W'($urandom), W'($urandom));
        wait_idle(6000);

        // Longest packet: LEN=255, eop at index 257
        push_pkt(8'h41, 8'h42, 8'hFF, 8'h43, 8'h44);
        wait_idle(4000);
        rdy_rand = 0;
        chk("final_depth", 32'(eq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
